// File: rtl/vec_act_stream.sv
// Handshaked multi-mode vector activation unit (pass / relu / leaky / clamp).
// Accepts one VEC_SIZE-element float vector, processes LANES elements per
// cycle over BEATS cycles, then presents the full result vector and the count
// of elements forced to +0.
module vec_act_stream #(
  parameter int unsigned VEC_SIZE   = 4,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 23,
  parameter int unsigned LANES      = 1,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [VEC_SIZE*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]  in_vec,
  input  logic [1:0]                                    in_mode,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]                 clamp_max,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [VEC_SIZE*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]  out_vec,
  output logic [$clog2(VEC_SIZE+1)-1:0]                 zero_count
);

  localparam int unsigned FW    = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned VW    = VEC_SIZE * FW;
  localparam int unsigned BEATS = VEC_SIZE / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ZW    = $clog2(VEC_SIZE + 1);

  // Reject parameter sets the datapath cannot honour.
  if (LANES == 0 || (VEC_SIZE % LANES) != 0) begin : g_lanes_chk
    $error("vec_act_stream: LANES must divide VEC_SIZE");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > (2**EXP_WIDTH) - 2) begin : g_leak_chk
    $error("vec_act_stream: LEAK_SHIFT out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [VW-1:0]          vec_q, vec_d;
  logic [1:0]             mode_q, mode_d;
  logic [FW-2:0]          clamp_q, clamp_d;
  logic [VW-1:0]          out_vec_q, out_vec_d;
  logic [ZW-1:0]          zc_q, zc_d;
  logic                   accept;
  logic [FW:0]            lane_res;
  int unsigned            idx;

  // The clamp bound is a magnitude; its sign bit carries no information.
  logic clamp_sign_unused;
  assign clamp_sign_unused = clamp_max[FW-1];

  // Per-element activation: returns {zeroed, result}.
  function automatic logic [FW:0] act_elem(input logic [1:0]    mode,
                                           input logic [FW-2:0] clamp,
                                           input logic [FW-1:0] x);
    logic                  s;
    logic [EXP_WIDTH-1:0]  e;
    logic [FRAC_WIDTH-1:0] f;
    logic [FW-1:0]         y;
    logic                  z;
    s = x[FW-1];
    e = x[FW-2:FRAC_WIDTH];
    f = x[FRAC_WIDTH-1:0];
    y = x;
    z = 1'b0;
    // NaN passes through untouched in every mode.
    if (!((&e) && (|f))) begin
      case (mode)
        2'd0: y = x;
        2'd1: begin
          if (s) begin
            y = '0;
            z = 1'b1;
          end
        end
        2'd2: begin
          if (s && !(&e)) begin
            if (e <= EXP_WIDTH'(LEAK_SHIFT)) begin
              y = '0;
              z = 1'b1;
            end else begin
              y = {1'b1, e - EXP_WIDTH'(LEAK_SHIFT), f};
            end
          end
        end
        default: begin
          if (s) begin
            y = '0;
            z = 1'b1;
          end else if (x[FW-2:0] > clamp) begin
            y = {1'b0, clamp};
          end
        end
      endcase
    end
    return {z, y};
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      vec_q     <= '0;
      mode_q    <= '0;
      clamp_q   <= '0;
      out_vec_q <= '0;
      zc_q      <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      vec_q     <= vec_d;
      mode_q    <= mode_d;
      clamp_q   <= clamp_d;
      out_vec_q <= out_vec_d;
      zc_q      <= zc_d;
    end
  end

  // Next-state, beat processing and handshake logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    vec_d     = vec_q;
    mode_d    = mode_q;
    clamp_d   = clamp_q;
    out_vec_d = out_vec_q;
    zc_d      = zc_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    lane_res  = '0;
    idx       = 0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      S_RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          idx      = 32'(beat_q) * LANES + l;
          lane_res = act_elem(mode_q, clamp_q, vec_q[idx*FW +: FW]);
          out_vec_d[idx*FW +: FW] = lane_res[FW-1:0];
          zc_d     = zc_d + ZW'(lane_res[FW]);
        end
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_DONE: begin
        // Back-to-back acceptance: result leaves as the next vector enters.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      vec_d   = in_vec;
      mode_d  = in_mode;
      clamp_d = clamp_max[FW-2:0];
      zc_d    = '0;
      beat_d  = '0;
      state_d = S_RUN;
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign out_vec    = out_vec_q;
  assign zero_count = zc_q;

endmodule

// File: tb/tb_vec_act_stream.sv
// Bench for vec_act_stream: scoreboard on the LANES=1 instance plus directed
// back-pressure / back-to-back checks on a LANES=2 instance.
module tb_vec_act_stream;

  localparam int unsigned FW    = 32;
  localparam int unsigned VW    = 4 * FW;
  localparam int unsigned ZW    = 3;
  localparam int unsigned BEATS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [VW-1:0] in_vec, out_vec;
  logic [1:0]    in_mode;
  logic [31:0]   clamp_max;
  logic [ZW-1:0] zero_count;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [VW-1:0] b_in_vec, b_out_vec;
  logic [1:0]    b_in_mode;
  logic [31:0]   b_clamp_max;
  logic [ZW-1:0] b_zero_count;

  vec_act_stream u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_mode(in_mode), .clamp_max(clamp_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .zero_count(zero_count)
  );

  vec_act_stream #(.LANES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .in_mode(b_in_mode), .clamp_max(b_clamp_max),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
    .zero_count(b_zero_count)
  );

  typedef struct packed {
    logic [VW-1:0] v;
    logic [ZW-1:0] zc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference element model: {zeroed, result}.
  function automatic logic [32:0] m_elem(input logic [1:0] m, input logic [31:0] c, input logic [31:0] x);
    logic [32:0] r;
    r = {1'b0, x};
    if (!(x[30:23] == 8'hFF && x[22:0] != 23'd0)) begin
      case (m)
        2'd0: r = {1'b0, x};
        2'd1: if (x[31]) r = {1'b1, 32'h0};
        2'd2: begin
          if (x[31] && x[30:23] != 8'hFF) begin
            if (x[30:23] <= 8'd3) r = {1'b1, 32'h0};
            else r = {2'b01, x[30:23] - 8'd3, x[22:0]};
          end
        end
        default: begin
          if (x[31]) r = {1'b1, 32'h0};
          else if (x[30:0] > c[30:0]) r = {2'b00, c[30:0]};
        end
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_elem();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 7))
      0: x = 32'h0000_0000;
      1: x = 32'h8000_0000;
      2: x = {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
      3: x = {1'($urandom), 8'hFF, 23'd0};
      4: x = {1'($urandom), 8'h00, 23'($urandom)};
      5: x = {1'b1, 8'($urandom_range(0, 5)), 23'($urandom)};
      default: x = $urandom;
    endcase
    return x;
  endfunction

  // Drive one vector on the LANES=1 instance, push its expectation, and
  // scramble the inputs while it runs; bp randomises out_ready.
  task automatic send(input logic [VW-1:0] v, input logic [1:0] m, input logic [31:0] c,
                      input logic [VW-1:0] ev, input logic [ZW-1:0] ezc, input bit bp);
    int   n;
    exp_t e;
    in_vec    = v;
    in_mode   = m;
    clamp_max = c;
    in_valid  = 1'b1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      n++;
    end
    chk("in_ready_wait", VW'(in_ready), VW'(1));
    e.v  = ev;
    e.zc = ezc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      in_vec    = {$urandom, $urandom, $urandom, $urandom};
      in_mode   = 2'($urandom);
      clamp_max = $urandom;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", VW'(n), VW'(BEATS));
  endtask

  // Scoreboard: compare every result transferred to the consumer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", VW'(sb.size() != 0), VW'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_vec", out_vec, e.v);
        chk("zero_count", VW'(zero_count), VW'(e.zc));
      end
    end
  end

  localparam logic [VW-1:0] T1_IN  = {32'h7FC00000, 32'h80000000, 32'hC0000000, 32'h3F800000};
  localparam logic [VW-1:0] T1_EXP = {32'h7FC00000, 32'h00000000, 32'h00000000, 32'h3F800000};
  localparam logic [VW-1:0] T2_IN  = {32'hFF800000, 32'h40400000, 32'h81000000, 32'hC0000000};
  localparam logic [VW-1:0] T2_EXP = {32'hFF800000, 32'h40400000, 32'h00000000, 32'hBE800000};
  localparam logic [VW-1:0] T3_IN  = {32'h7F800000, 32'hC1200000, 32'h40000000, 32'h41200000};
  localparam logic [VW-1:0] T3_EXP = {32'h40C00000, 32'h00000000, 32'h40000000, 32'h40C00000};

  initial begin
    int            n;
    logic [VW-1:0] v, ev;
    logic [ZW-1:0] ezc;
    logic [1:0]    m;
    logic [31:0]   c;
    logic [32:0]   r;

    rst_n = 1'b0;
    in_valid = 1'b0; in_vec = '0; in_mode = '0; clamp_max = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_vec = '0; b_in_mode = '0; b_clamp_max = '0; b_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_out_vec", out_vec, '0);
    chk("rst_zero_count", VW'(zero_count), VW'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors for relu, leaky and clamp.
    send(T1_IN, 2'd1, 32'h0, T1_EXP, 3'd2, 1'b0);
    send(T2_IN, 2'd2, 32'h0, T2_EXP, 3'd1, 1'b0);
    send(T3_IN, 2'd3, 32'h40C00000, T3_EXP, 3'd1, 1'b0);

    // Random vectors across all modes with random back-pressure.
    for (int i = 0; i < 16; i++) begin
      m   = 2'(i);
      c   = {1'($urandom), 8'($urandom_range(100, 140)), 23'($urandom)};
      ev  = '0;
      ezc = '0;
      for (int k = 0; k < 4; k++) begin
        v[k*32 +: 32]  = rand_elem();
        r              = m_elem(m, c, v[k*32 +: 32]);
        ev[k*32 +: 32] = r[31:0];
        ezc            = ezc + ZW'(r[32]);
      end
      send(v, m, c, ev, ezc, 1'b1);
    end

    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain1", VW'(sb.size()), VW'(0));

    // Asynchronous reset during RUN beat 2 abandons the vector.
    in_vec = T1_IN; in_mode = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", VW'(out_valid), VW'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", VW'(in_ready), VW'(1));
    chk("midrst_out_valid", VW'(out_valid), VW'(0));
    chk("midrst_zero_count", VW'(zero_count), VW'(0));
    chk("midrst_out_vec", out_vec, '0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(T2_IN, 2'd2, 32'h0, T2_EXP, 3'd1, 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain2", VW'(sb.size()), VW'(0));

    // LANES=2: hold in DONE, then back-to-back handshake.
    b_in_vec = T1_IN; b_in_mode = 2'd1; b_in_valid = 1'b1;
    #1;
    chk("l2_idle_ready", VW'(b_in_ready), VW'(1));
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_mode = 2'd3; b_clamp_max = 32'h0;
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("l2_latency_a", VW'(n), VW'(2));
    chk("l2_zc_a", VW'(b_zero_count), VW'(2));
    for (int i = 0; i < 5; i++) begin
      chk("l2_hold_vec", b_out_vec, T1_EXP);
      chk("l2_hold_in_ready", VW'(b_in_ready), VW'(0));
      chk("l2_hold_valid", VW'(b_out_valid), VW'(1));
      @(posedge clk); #1;
    end
    b_in_vec = T3_IN; b_in_mode = 2'd3; b_clamp_max = 32'h40C00000;
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    chk("l2_b2b_in_ready", VW'(b_in_ready), VW'(1));
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_mode = 2'd0; b_clamp_max = 32'h0;
    chk("l2_b2b_run", VW'(b_out_valid), VW'(0));
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("l2_latency_b", VW'(n), VW'(2));
    chk("l2_vec_b", b_out_vec, T3_EXP);
    chk("l2_zc_b", VW'(b_zero_count), VW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_act_stream.md
Name: vec_act_stream

Overview:
- Multi-mode, handshaked vector activation unit; successor to the combinational per-element ReLU vector stage.
- Accepts one VEC_SIZE-element float vector per transaction and processes LANES elements per cycle over BEATS = VEC_SIZE/LANES cycles.
- Presents the full result vector with valid/ready plus a count of elements forced to zero.
- Sits between the matmul accumulator output and the next layer's input buffer.

Parameters:
VEC_SIZE, 4, elements per vector
EXP_WIDTH, 8, float exponent bits
FRAC_WIDTH, 23, float fraction bits; FW = 1+EXP_WIDTH+FRAC_WIDTH
LANES, 1, elements processed per cycle; must divide VEC_SIZE (elaboration error otherwise)
LEAK_SHIFT, 3, leaky-mode slope 2^-LEAK_SHIFT; range 1..2^EXP_WIDTH-2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in_vec  input  VEC_SIZE*FW  element i at bits [i*FW +: FW]
in_mode  input  2  0 pass, 1 relu, 2 leaky, 3 clamp; sampled at acceptance
clamp_max  input  FW  positive upper bound for mode 3; sampled at acceptance
out_valid  output  1  result vector valid
out_ready  input  1  consumer accepts result
out_vec  output  VEC_SIZE*FW  result, same packing as in_vec
zero_count  output  $clog2(VEC_SIZE+1)  elements whose result was forced to +0 this vector

Behaviour:
- Reset (async, rst_n low): state IDLE, in_ready=1, out_valid=0, out_vec=0, zero_count=0, beat counter=0. Reset mid-RUN or in DONE abandons the vector with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_vec, in_mode and clamp_max; clear zero_count; go to RUN with beat=0.
  - RUN: in_ready=0. Each cycle, transform elements beat*LANES .. beat*LANES+LANES-1 into the out_vec slots and add the number of zeroed elements to zero_count. On beat=BEATS-1, go to DONE. Otherwise increment beat.
  - DONE: out_valid=1 and out_vec/zero_count held stable. in_ready = out_ready (combinational).
    - out_ready & in_valid: accept the new vector and go to RUN (no bubble).
    - out_ready only: go to IDLE.
    - No out_ready: hold.
- Latency: out_valid rises BEATS cycles after the acceptance edge. Throughput is one vector per BEATS+1 cycles.
- in_vec, in_mode and clamp_max are ignored outside acceptance. Changes during RUN have no effect.
- Element rules (s = sign, e = exponent, f = fraction):
  - NaN (e all ones, f≠0): output unchanged in every mode; not counted.
  - Mode 0: output = input.
  - Mode 1: if s=1 (including -0, negative denormals, -inf), output +0 and count it. Otherwise unchanged.
  - Mode 2 (s=0): unchanged.
  - Mode 2 (s=1), e=all ones (-inf): unchanged.
  - Mode 2 (s=1), e ≤ LEAK_SHIFT (underflow, including denormals and -0): output +0 and count it.
  - Mode 2 (s=1), otherwise: output is {1, e-LEAK_SHIFT, f}.
  - Mode 3: apply the relu rule (zeroing and counting as in mode 1). Then, if the unsigned compare of {e,f} exceeds clamp_max[FW-2:0], output clamp_max with sign forced to 0. +inf clamps. clamp_max sign bit is ignored.
- zero_count saturates at VEC_SIZE by construction; its width must hold VEC_SIZE.

Test Plan:
- Reset release, VEC_SIZE=4, LANES=1, mode 1, in_vec {0x3F800000, 0xC0000000, 0x80000000, 0x7FC00000} → out_valid exactly 4 cycles after acceptance; out {0x3F800000, 0, 0, 0x7FC00000}; zero_count=2.
- Mode 2, LEAK_SHIFT=3, in {0xC0000000, 0x81000000, 0x40400000, 0xFF800000} → {0xBE800000, 0, 0x40400000, 0xFF800000}; zero_count=1.
- Mode 3, clamp_max=0x40C00000, in {0x41200000, 0x40000000, 0xC1200000, 0x7F800000} → {0x40C00000, 0x40000000, 0, 0x40C00000}; zero_count=1.
- LANES=2: hold out_ready=0 for 5 cycles in DONE → out_vec stable and in_ready=0. Then assert out_ready with in_valid=1 → next vector accepted on the same edge, and its out_valid follows 2 cycles later.
- Assert rst_n low during RUN beat 2 → out_valid=0, in_ready=1 immediately (async). After release, a fresh vector processes correctly with zero_count counted from 0.
- Change in_mode and clamp_max every cycle during RUN → results reflect only the values sampled at acceptance.
